// File: rtl/ga23_sdr_arbiter.sv
// GA23 background-layer SDRAM read arbiter.
// Each playfield layer fires one-cycle fetch pulses. The arbiter keeps one
// pending slot per layer, grants round-robin with a single access in flight,
// and parks each returned row in a per-layer holding register.
//
// Handshakes:
//   layer_req[i] : one-cycle fire-and-forget pulse with no back-pressure.
//                  A second pulse before the first is granted replaces the
//                  address and raises overrun[i] for one cycle.
//   sdr_req      : one-cycle pulse while the FSM is in ISSUE. sdr_addr is
//                  stable from that cycle until completion. The controller
//                  answers with exactly one sdr_rdy pulse, either in the
//                  sdr_req cycle itself or any later cycle. sdr_data is
//                  valid only while sdr_rdy=1.
//   layer_rdy[i] : one-cycle strobe. layer_data[i] is updated in the same
//                  cycle and then held until that layer's next completion.
module ga23_sdr_arbiter #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LAYERS-1:0]        layer_req,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  output logic [NUM_LAYERS*DATA_W-1:0] layer_data,
  output logic [NUM_LAYERS-1:0]        layer_rdy,
  output logic [NUM_LAYERS-1:0]        overrun,
  output logic                         busy,
  output logic [ADDR_W-1:0]            sdr_addr,
  output logic                         sdr_req,
  input  logic [DATA_W-1:0]            sdr_data,
  input  logic                         sdr_rdy,
  output logic [1:0]                   state_dbg
);

  localparam int LG_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [NUM_LAYERS-1:0] pend;
  logic [ADDR_W-1:0]     addr_q [NUM_LAYERS];
  logic [LG_W-1:0]       last_grant;
  logic [LG_W-1:0]       gnt;

  logic                  found;
  logic [LG_W-1:0]       pick;
  logic [LG_W-1:0]       cand;
  logic                  do_grant;
  logic [NUM_LAYERS-1:0] grant_mask;
  logic                  complete;

  // Round-robin search over registered pend, starting just after last_grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_LAYERS; k++) begin
      cand = LG_W'((int'(last_grant) + k) % NUM_LAYERS);
      if (!found && pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Grant and completion qualifiers, plus state-decoded outputs.
  always_comb begin
    do_grant   = (state == S_IDLE) && found;
    grant_mask = do_grant ? (NUM_LAYERS'(1) << pick) : '0;
    complete   = ((state == S_ISSUE) || (state == S_WAIT)) && sdr_rdy;
    busy       = (state != S_IDLE);
    sdr_req    = (state == S_ISSUE);
    state_dbg  = state;
  end

  // Pending slots: a new pulse always wins over a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (layer_req[i]) begin
          pend[i]   <= 1'b1;
          addr_q[i] <= layer_addr[i*ADDR_W +: ADDR_W];
        end else if (grant_mask[i]) begin
          pend[i] <= 1'b0;
        end
      end
      // A slot being granted this cycle is no longer "waiting", so a
      // request landing on it is a fresh request rather than an overrun.
      overrun <= layer_req & pend & ~grant_mask;
    end
  end

  // Access FSM: IDLE grants, ISSUE pulses sdr_req, WAIT holds for sdr_rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= LG_W'(NUM_LAYERS - 1);
      gnt        <= '0;
      sdr_addr   <= '0;
      layer_data <= '0;
      layer_rdy  <= '0;
    end else begin
      layer_rdy <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt        <= pick;
            last_grant <= pick;
            sdr_addr   <= addr_q[pick];
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= sdr_rdy ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (sdr_rdy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (complete) begin
        layer_data[gnt*DATA_W +: DATA_W] <= sdr_data;
        layer_rdy[gnt]                   <= 1'b1;
      end
    end
  end

endmodule
